// File: rtl/exu_pkg.sv
// Shared encodings for the RV32I execute-stage control unit.
// Holds opcode constants, the immediate-type, ALU-control, ALU B-source and
// branch encodings, plus the func3 -> ALU-control mapping.
package exu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    EXT_I = 3'b000,
    EXT_U = 3'b001,
    EXT_S = 3'b010,
    EXT_B = 3'b011,
    EXT_J = 3'b100
  } ext_op_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b1000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b1010,
    ALU_COPYB = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SRA   = 4'b1101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111
  } alu_ctr_e;

  typedef enum logic [1:0] {
    BSRC_RS2  = 2'b00,
    BSRC_IMM  = 2'b01,
    BSRC_FOUR = 2'b10
  } alu_b_src_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_JAL  = 3'b001,
    BR_JALR = 3'b010,
    BR_BEQ  = 3'b100,
    BR_BNE  = 3'b101,
    BR_BLT  = 3'b110,
    BR_BGE  = 3'b111
  } branch_e;

  // Map an arithmetic func3 to ALU control; alt picks sub (000) or sra (101).
  function automatic alu_ctr_e alu_ctr_from_f3(input logic [2:0] f3, input logic alt);
    alu_ctr_e ctr;
    case (f3)
      3'b000:  ctr = alt ? ALU_SUB : ALU_ADD;
      3'b001:  ctr = ALU_SLL;
      3'b010:  ctr = ALU_SLT;
      3'b011:  ctr = ALU_SLTU;
      3'b100:  ctr = ALU_XOR;
      3'b101:  ctr = alt ? ALU_SRA : ALU_SRL;
      3'b110:  ctr = ALU_OR;
      3'b111:  ctr = ALU_AND;
      default: ctr = ALU_ADD;
    endcase
    return ctr;
  endfunction

endpackage

// File: rtl/exu_alu.sv
// Combinational 32-bit ALU for the execute stage.
// Less compares signed when ctr[3]=0 and unsigned when ctr[3]=1, so the
// slt/sltu encodings double as the signed/unsigned branch compare select.
module exu_alu
  import exu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_ctr,
  output logic [31:0] o_out,
  output logic        o_less,
  output logic        o_zero
);

  logic [4:0] w_shamt;

  assign w_shamt = i_b[4:0];

  // Compare flags shared by slt/sltu and the branch condition logic.
  always_comb begin
    o_zero = (i_a == i_b);
    if (i_ctr[3]) begin
      o_less = (i_a < i_b);
    end else begin
      o_less = ($signed(i_a) < $signed(i_b));
    end
  end

  // Result mux selected by the ALU control code.
  always_comb begin
    o_out = 32'd0;
    case (i_ctr)
      ALU_ADD:   o_out = i_a + i_b;
      ALU_SUB:   o_out = i_a - i_b;
      ALU_SLL:   o_out = i_a << w_shamt;
      ALU_SLT:   o_out = {31'd0, o_less};
      ALU_SLTU:  o_out = {31'd0, o_less};
      ALU_COPYB: o_out = i_b;
      ALU_XOR:   o_out = i_a ^ i_b;
      ALU_SRL:   o_out = i_a >> w_shamt;
      ALU_SRA:   o_out = $signed(i_a) >>> w_shamt;
      ALU_OR:    o_out = i_a | i_b;
      ALU_AND:   o_out = i_a & i_b;
      default:   o_out = 32'd0;
    endcase
  end

endmodule

// File: rtl/exec_ctrl_unit.sv
// RV32I execute-stage control unit: decode, ALU, branch resolution and
// next-PC generation behind a single output register. ext_op stays
// combinational so the upstream immediate generator can use it same-cycle.
// Optional macro EXU_ILLEGAL_DET_EN adds a registered 'illegal' flag; without
// it the same malformed encodings still decode silently as a NOP.
module exec_ctrl_unit
  import exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [6:0]      op,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic [2:0]      ext_op,
  output logic            out_valid,
  output logic            reg_wr,
  output logic            mem_to_reg,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [2:0]      mem_op,
  output logic [XLEN-1:0] alu_out,
  output logic            pc_a_src,
  output logic            pc_b_src,
`ifdef EXU_ILLEGAL_DET_EN
  output logic            illegal,
`endif
  output logic [XLEN-1:0] next_pc
);

  // Raw decode, before malformed encodings are squashed to NOP.
  ext_op_e    w_dec_ext;
  logic       w_dec_a_src;
  alu_b_src_e w_dec_b_src;
  alu_ctr_e   w_dec_ctr;
  branch_e    w_dec_br;
  logic       w_dec_reg_wr;
  logic       w_dec_mem_to_reg;
  logic       w_dec_mem_rd;
  logic       w_dec_mem_wr;
  logic       w_illegal;

  // Final controls.
  ext_op_e    w_ext;
  logic       w_alu_a_src;
  alu_b_src_e w_alu_b_src;
  alu_ctr_e   w_alu_ctr;
  branch_e    w_branch;
  logic       w_reg_wr;
  logic       w_mem_to_reg;
  logic       w_mem_rd;
  logic       w_mem_wr;

  logic [XLEN-1:0] w_alu_a;
  logic [XLEN-1:0] w_alu_b;
  logic [XLEN-1:0] w_alu_out;
  logic            w_less;
  logic            w_zero;
  logic            w_pc_a_src;
  logic            w_pc_b_src;
  logic [XLEN-1:0] w_pc_sum;
  logic [XLEN-1:0] w_next_pc;

  logic            r_out_valid;
  logic            r_reg_wr;
  logic            r_mem_to_reg;
  logic            r_mem_rd;
  logic            r_mem_wr;
  logic [2:0]      r_mem_op;
  logic [XLEN-1:0] r_alu_out;
  logic            r_pc_a_src;
  logic            r_pc_b_src;
  logic [XLEN-1:0] r_next_pc;
  logic            r_illegal;

  // Opcode/func3/func7 decode into datapath controls plus a malformed flag.
  always_comb begin
    w_dec_ext        = EXT_I;
    w_dec_a_src      = 1'b0;
    w_dec_b_src      = BSRC_RS2;
    w_dec_ctr        = ALU_ADD;
    w_dec_br         = BR_NONE;
    w_dec_reg_wr     = 1'b0;
    w_dec_mem_to_reg = 1'b0;
    w_dec_mem_rd     = 1'b0;
    w_dec_mem_wr     = 1'b0;
    w_illegal        = 1'b0;
    case (op)
      OPC_LUI: begin
        w_dec_ext    = EXT_U;
        w_dec_ctr    = ALU_COPYB;
        w_dec_b_src  = BSRC_IMM;
        w_dec_reg_wr = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec_ext    = EXT_U;
        w_dec_a_src  = 1'b1;
        w_dec_b_src  = BSRC_IMM;
        w_dec_reg_wr = 1'b1;
      end
      OPC_JAL: begin
        w_dec_ext    = EXT_J;
        w_dec_a_src  = 1'b1;
        w_dec_b_src  = BSRC_FOUR;
        w_dec_reg_wr = 1'b1;
        w_dec_br     = BR_JAL;
      end
      OPC_JALR: begin
        w_dec_a_src  = 1'b1;
        w_dec_b_src  = BSRC_FOUR;
        w_dec_reg_wr = 1'b1;
        w_dec_br     = BR_JALR;
        w_illegal    = (func3 != 3'b000);
      end
      OPC_BRANCH: begin
        w_dec_ext = EXT_B;
        case (func3)
          3'b000: begin w_dec_br = BR_BEQ; w_dec_ctr = ALU_SUB;  end
          3'b001: begin w_dec_br = BR_BNE; w_dec_ctr = ALU_SUB;  end
          3'b100: begin w_dec_br = BR_BLT; w_dec_ctr = ALU_SLT;  end
          3'b101: begin w_dec_br = BR_BGE; w_dec_ctr = ALU_SLT;  end
          3'b110: begin w_dec_br = BR_BLT; w_dec_ctr = ALU_SLTU; end
          3'b111: begin w_dec_br = BR_BGE; w_dec_ctr = ALU_SLTU; end
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_dec_b_src      = BSRC_IMM;
        w_dec_mem_rd     = 1'b1;
        w_dec_mem_to_reg = 1'b1;
        w_dec_reg_wr     = 1'b1;
        case (func3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
          default:                                w_illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        w_dec_ext    = EXT_S;
        w_dec_b_src  = BSRC_IMM;
        w_dec_mem_wr = 1'b1;
        w_illegal    = (func3 > 3'b010);
      end
      OPC_OPIMM: begin
        w_dec_b_src  = BSRC_IMM;
        w_dec_reg_wr = 1'b1;
        // func7 only carries meaning for the shift-immediates.
        w_dec_ctr    = alu_ctr_from_f3(func3, func7[5] & (func3 == 3'b101));
        case (func3)
          3'b001:  w_illegal = (func7 != F7_BASE);
          3'b101:  w_illegal = (func7 != F7_BASE) && (func7 != F7_ALT);
          default: w_illegal = 1'b0;
        endcase
      end
      OPC_OP: begin
        w_dec_b_src  = BSRC_RS2;
        w_dec_reg_wr = 1'b1;
        w_dec_ctr    = alu_ctr_from_f3(func3, func7[5]);
        w_illegal    = !((func7 == F7_BASE) ||
                         ((func7 == F7_ALT) && ((func3 == 3'b000) || (func3 == 3'b101))));
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Squash malformed encodings to a NOP, whether or not the flag is exported.
  always_comb begin
    if (w_illegal) begin
      w_ext        = EXT_I;
      w_alu_a_src  = 1'b0;
      w_alu_b_src  = BSRC_RS2;
      w_alu_ctr    = ALU_ADD;
      w_branch     = BR_NONE;
      w_reg_wr     = 1'b0;
      w_mem_to_reg = 1'b0;
      w_mem_rd     = 1'b0;
      w_mem_wr     = 1'b0;
    end else begin
      w_ext        = w_dec_ext;
      w_alu_a_src  = w_dec_a_src;
      w_alu_b_src  = w_dec_b_src;
      w_alu_ctr    = w_dec_ctr;
      w_branch     = w_dec_br;
      w_reg_wr     = w_dec_reg_wr;
      w_mem_to_reg = w_dec_mem_to_reg;
      w_mem_rd     = w_dec_mem_rd;
      w_mem_wr     = w_dec_mem_wr;
    end
  end

  assign ext_op = w_ext;

  // ALU operand selection.
  always_comb begin
    w_alu_a = w_alu_a_src ? pc : rs1_data;
    case (w_alu_b_src)
      BSRC_RS2:  w_alu_b = rs2_data;
      BSRC_IMM:  w_alu_b = imm;
      BSRC_FOUR: w_alu_b = 32'd4;
      default:   w_alu_b = 32'd0;
    endcase
  end

  exu_alu u_alu (
    .i_a    (w_alu_a),
    .i_b    (w_alu_b),
    .i_ctr  (w_alu_ctr),
    .o_out  (w_alu_out),
    .o_less (w_less),
    .o_zero (w_zero)
  );

  // Branch condition resolves the next-PC addend and base selects.
  always_comb begin
    w_pc_a_src = 1'b0;
    w_pc_b_src = 1'b0;
    case (w_branch)
      BR_NONE: begin w_pc_a_src = 1'b0;    w_pc_b_src = 1'b0; end
      BR_JAL:  begin w_pc_a_src = 1'b1;    w_pc_b_src = 1'b0; end
      BR_JALR: begin w_pc_a_src = 1'b1;    w_pc_b_src = 1'b1; end
      BR_BEQ:  begin w_pc_a_src = w_zero;  w_pc_b_src = 1'b0; end
      BR_BNE:  begin w_pc_a_src = !w_zero; w_pc_b_src = 1'b0; end
      BR_BLT:  begin w_pc_a_src = w_less;  w_pc_b_src = 1'b0; end
      BR_BGE:  begin w_pc_a_src = !w_less; w_pc_b_src = 1'b0; end
      default: begin w_pc_a_src = 1'b0;    w_pc_b_src = 1'b0; end
    endcase
  end

  // Next-PC adder; jalr targets are forced halfword-aligned.
  always_comb begin
    w_pc_sum = (w_pc_a_src ? imm : 32'd4) + (w_pc_b_src ? rs1_data : pc);
    if (w_branch == BR_JALR) begin
      w_next_pc = {w_pc_sum[XLEN-1:1], 1'b0};
    end else begin
      w_next_pc = w_pc_sum;
    end
  end

  // Output pipeline register; side-effecting enables are gated by in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_reg_wr     <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_op     <= 3'd0;
      r_alu_out    <= 32'd0;
      r_pc_a_src   <= 1'b0;
      r_pc_b_src   <= 1'b0;
      r_next_pc    <= 32'd0;
      r_illegal    <= 1'b0;
    end else begin
      r_out_valid  <= in_valid;
      r_reg_wr     <= in_valid & w_reg_wr;
      r_mem_to_reg <= w_mem_to_reg;
      r_mem_rd     <= in_valid & w_mem_rd;
      r_mem_wr     <= in_valid & w_mem_wr;
      r_mem_op     <= func3;
      r_alu_out    <= w_alu_out;
      r_pc_a_src   <= w_pc_a_src;
      r_pc_b_src   <= w_pc_b_src;
      r_next_pc    <= w_next_pc;
      r_illegal    <= in_valid & w_illegal;
    end
  end

  assign out_valid  = r_out_valid;
  assign reg_wr     = r_reg_wr;
  assign mem_to_reg = r_mem_to_reg;
  assign mem_rd     = r_mem_rd;
  assign mem_wr     = r_mem_wr;
  assign mem_op     = r_mem_op;
  assign alu_out    = r_alu_out;
  assign pc_a_src   = r_pc_a_src;
  assign pc_b_src   = r_pc_b_src;
  assign next_pc    = r_next_pc;

`ifdef EXU_ILLEGAL_DET_EN
  assign illegal = r_illegal;
`else
  // The malformed flag still drives the NOP squash; only the port is absent.
  logic w_illegal_unused;
  assign w_illegal_unused = r_illegal;
`endif

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Directed testbench for exec_ctrl_unit with hand-computed expectations.
module tb_exec_ctrl_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [2:0]  ext_op;
  logic        out_valid;
  logic        reg_wr;
  logic        mem_to_reg;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  mem_op;
  logic [31:0] alu_out;
  logic        pc_a_src;
  logic        pc_b_src;
  logic [31:0] next_pc;
`ifdef EXU_ILLEGAL_DET_EN
  logic        illegal;
`endif

  int tests_run;
  int tests_failed;

  exec_ctrl_unit dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .op         (op),
    .func3      (func3),
    .func7      (func7),
    .pc         (pc),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .imm        (imm),
    .ext_op     (ext_op),
    .out_valid  (out_valid),
    .reg_wr     (reg_wr),
    .mem_to_reg (mem_to_reg),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_op     (mem_op),
    .alu_out    (alu_out),
    .pc_a_src   (pc_a_src),
    .pc_b_src   (pc_b_src),
`ifdef EXU_ILLEGAL_DET_EN
    .illegal    (illegal),
`endif
    .next_pc    (next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {out_valid, reg_wr, mem_to_reg, mem_rd, mem_wr, pc_a_src, pc_b_src}
  function automatic logic [31:0] ctl();
    return {25'd0, out_valid, reg_wr, mem_to_reg, mem_rd, mem_wr, pc_a_src, pc_b_src};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im);
    in_valid = v; op = o; func3 = f3; func7 = f7;
    pc = p; rs1_data = a; rs2_data = b; imm = im;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;

    // Reset with a valid OP instruction present: reset wins.
    rst = 1'b1;
    drive(1'b1, 7'b0110011, 3'b000, 7'b0000000, 32'h10, 32'd3, 32'd4, 32'd0);
    step();
    check_eq("rst_ctl", ctl(), 32'h00);
    check_eq("rst_alu", alu_out, 32'h0);
    check_eq("rst_npc", next_pc, 32'h0);
    check_eq("rst_memop", {29'd0, mem_op}, 32'h0);
    rst = 1'b0;

    // OP sub
    drive(1'b1, 7'b0110011, 3'b000, 7'b0100000, 32'h1000, 32'd5, 32'd7, 32'd0);
    step();
    check_eq("sub_alu", alu_out, 32'hFFFFFFFE);
    check_eq("sub_ctl", ctl(), 32'h60);
    check_eq("sub_npc", next_pc, 32'h1004);

    // OP-IMM srai
    drive(1'b1, 7'b0010011, 3'b101, 7'b0100000, 32'h2000, 32'h80000000, 32'd0, 32'h401);
    step();
    check_eq("srai_alu", alu_out, 32'hC0000000);
    check_eq("srai_ctl", ctl(), 32'h60);

    // blt signed taken
    drive(1'b1, 7'b1100011, 3'b100, 7'b0000000, 32'h80000000, 32'hFFFFFFFF, 32'd1, 32'h10);
    #1;
    check_eq("blt_ext", {29'd0, ext_op}, 32'h3);
    step();
    check_eq("blt_ctl", ctl(), 32'h42);
    check_eq("blt_npc", next_pc, 32'h80000010);
    check_eq("blt_alu", alu_out, 32'h1);

    // bltu same operands not taken
    drive(1'b1, 7'b1100011, 3'b110, 7'b0000000, 32'h80000000, 32'hFFFFFFFF, 32'd1, 32'h10);
    step();
    check_eq("bltu_ctl", ctl(), 32'h40);
    check_eq("bltu_npc", next_pc, 32'h80000004);
    check_eq("bltu_alu", alu_out, 32'h0);

    // bgeu taken
    drive(1'b1, 7'b1100011, 3'b111, 7'b0000000, 32'h300, 32'hFFFFFFFF, 32'd1, 32'h40);
    step();
    check_eq("bgeu_npc", next_pc, 32'h340);

    // JALR with odd target
    drive(1'b1, 7'b1100111, 3'b000, 7'b0000000, 32'h80000020, 32'h80000101, 32'd0, 32'd4);
    step();
    check_eq("jalr_alu", alu_out, 32'h80000024);
    check_eq("jalr_ctl", ctl(), 32'h63);
    check_eq("jalr_npc", next_pc, 32'h80000104);

    // STORE, ext_op checked before the edge
    drive(1'b1, 7'b0100011, 3'b010, 7'b0000000, 32'h500, 32'h100, 32'h55, 32'hFFFFFFFC);
    #1;
    check_eq("sw_ext", {29'd0, ext_op}, 32'h2);
    step();
    check_eq("sw_alu", alu_out, 32'hFC);
    check_eq("sw_ctl", ctl(), 32'h44);
    check_eq("sw_memop", {29'd0, mem_op}, 32'h2);

    // Bubble after the store
    in_valid = 1'b0;
    step();
    check_eq("bubble_en", {28'd0, out_valid, reg_wr, mem_rd, mem_wr}, 32'h0);

    // LUI
    drive(1'b1, 7'b0110111, 3'b000, 7'b0000000, 32'h600, 32'hDEAD, 32'd0, 32'h12345000);
    #1;
    check_eq("lui_ext", {29'd0, ext_op}, 32'h1);
    step();
    check_eq("lui_alu", alu_out, 32'h12345000);
    check_eq("lui_ctl", ctl(), 32'h60);

    // AUIPC
    drive(1'b1, 7'b0010111, 3'b000, 7'b0000000, 32'h400, 32'd0, 32'd0, 32'h1000);
    step();
    check_eq("auipc_alu", alu_out, 32'h1400);

    // JAL
    drive(1'b1, 7'b1101111, 3'b000, 7'b0000000, 32'h100, 32'd0, 32'd0, 32'h20);
    #1;
    check_eq("jal_ext", {29'd0, ext_op}, 32'h4);
    step();
    check_eq("jal_alu", alu_out, 32'h104);
    check_eq("jal_npc", next_pc, 32'h120);
    check_eq("jal_ctl", ctl(), 32'h62);

    // beq taken, negative offset
    drive(1'b1, 7'b1100011, 3'b000, 7'b0000000, 32'h200, 32'd7, 32'd7, 32'hFFFFFFF0);
    step();
    check_eq("beq_npc", next_pc, 32'h1F0);
    check_eq("beq_ctl", ctl(), 32'h42);

    // bne with equal operands: not taken
    drive(1'b1, 7'b1100011, 3'b001, 7'b0000000, 32'h200, 32'd7, 32'd7, 32'hFFFFFFF0);
    step();
    check_eq("bne_npc", next_pc, 32'h204);

    // LOAD lbu
    drive(1'b1, 7'b0000011, 3'b100, 7'b0000000, 32'h700, 32'h1000, 32'd0, 32'd8);
    step();
    check_eq("lbu_alu", alu_out, 32'h1008);
    check_eq("lbu_ctl", ctl(), 32'h78);
    check_eq("lbu_memop", {29'd0, mem_op}, 32'h4);

    // sltu / slt
    drive(1'b1, 7'b0110011, 3'b011, 7'b0000000, 32'h0, 32'd1, 32'hFFFFFFFF, 32'd0);
    step();
    check_eq("sltu_alu", alu_out, 32'h1);
    drive(1'b1, 7'b0110011, 3'b010, 7'b0000000, 32'h0, 32'd1, 32'hFFFFFFFF, 32'd0);
    step();
    check_eq("slt_alu", alu_out, 32'h0);

    // addi ignores func7[5]
    drive(1'b1, 7'b0010011, 3'b000, 7'b0100000, 32'h0, 32'd10, 32'd0, 32'h405);
    step();
    check_eq("addi_alu", alu_out, 32'h40F);

    // sll uses only rs2[4:0]
    drive(1'b1, 7'b0110011, 3'b001, 7'b0000000, 32'h0, 32'd1, 32'h23, 32'd0);
    step();
    check_eq("sll_alu", alu_out, 32'h8);

    // sra / srl
    drive(1'b1, 7'b0110011, 3'b101, 7'b0100000, 32'h0, 32'hF0000000, 32'd4, 32'd0);
    step();
    check_eq("sra_alu", alu_out, 32'hFF000000);
    drive(1'b1, 7'b0110011, 3'b101, 7'b0000000, 32'h0, 32'hF0000000, 32'd4, 32'd0);
    step();
    check_eq("srl_alu", alu_out, 32'h0F000000);

    // Unknown opcode decodes as NOP
    drive(1'b1, 7'b1111111, 3'b000, 7'b0000000, 32'h900, 32'd1, 32'd2, 32'h80);
    #1;
    check_eq("nop_ext", {29'd0, ext_op}, 32'h0);
    step();
    check_eq("nop_ctl", ctl(), 32'h40);
    check_eq("nop_npc", next_pc, 32'h904);
`ifdef EXU_ILLEGAL_DET_EN
    check_eq("nop_ill", {31'd0, illegal}, 32'h1);
`endif

    // Branch with reserved func3 decodes as NOP
    drive(1'b1, 7'b1100011, 3'b010, 7'b0000000, 32'hA00, 32'd7, 32'd7, 32'h40);
    step();
    check_eq("badbr_ctl", ctl(), 32'h40);
    check_eq("badbr_npc", next_pc, 32'hA04);
`ifdef EXU_ILLEGAL_DET_EN
    check_eq("badbr_ill", {31'd0, illegal}, 32'h1);
`endif

    // OP with bad func7 on add-variant and: NOP
    drive(1'b1, 7'b0110011, 3'b111, 7'b0100000, 32'hB00, 32'hFF, 32'h0F, 32'd0);
    step();
    check_eq("badop_ctl", ctl(), 32'h40);

    // Mid-run reset clears non-zero outputs
    drive(1'b1, 7'b1101111, 3'b011, 7'b0000000, 32'h100, 32'd0, 32'd0, 32'h20);
    step();
    rst = 1'b1;
    step();
    check_eq("rst2_ctl", ctl(), 32'h00);
    check_eq("rst2_alu", alu_out, 32'h0);
    check_eq("rst2_npc", next_pc, 32'h0);
    check_eq("rst2_memop", {29'd0, mem_op}, 32'h0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
